// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache, 8 lines x 128 bits, sitting between CPU and block memory.
// Latency: hits complete with no stall; a clean miss stalls 4 edges and a dirty miss 6 edges against a one-edge memory.
// Backpressure: CPU_BUSYWAIT holds the CPU during a miss; MEM_BUSYWAIT stretches the WRITEBACK and FETCH states.
module dcache_controller (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         CPU_READ,
   input  logic         CPU_WRITE,
   input  logic [31:0]  CPU_ADDRESS,
   input  logic [31:0]  CPU_WRITEDATA,
   output logic [31:0]  CPU_READDATA,
   output logic         CPU_BUSYWAIT,
   output logic         MEM_READ,
   output logic         MEM_WRITE,
   output logic [27:0]  MEM_ADDRESS,
   output logic [127:0] MEM_WRITEDATA,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FETCH     = 2'd2,
      S_UPDATE    = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           mem_read_q, mem_read_d;
   logic           mem_write_q, mem_write_d;
   logic [27:0]    mem_address_q, mem_address_d;
   logic [127:0]   mem_writedata_q, mem_writedata_d;
   logic [127:0]   buffer_q, buffer_d;
   // Set once a memory request has been seen at an edge; the first edge of a request is never its completion.
   logic           req_old_q, req_old_d;

   logic [127:0]   data_q [8];
   logic [127:0]   data_d [8];
   logic [24:0]    tag_q [8];
   logic [24:0]    tag_d [8];
   logic [7:0]     valid_q, valid_d;
   logic [7:0]     dirty_q, dirty_d;

   logic [24:0]    addr_tag;
   logic [2:0]     addr_idx;
   logic [6:0]     word_lsb;
   logic           access;
   logic           hit;
   logic           mem_done;
   logic           unused_addr_bits;

   assign addr_tag         = CPU_ADDRESS[31:7];
   assign addr_idx         = CPU_ADDRESS[6:4];
   assign word_lsb         = {CPU_ADDRESS[3:2], 5'd0};
   assign unused_addr_bits = ^CPU_ADDRESS[1:0];

   // Read and write together, or neither, is not an access.
   assign access   = CPU_READ ^ CPU_WRITE;
   assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
   assign mem_done = !MEM_BUSYWAIT && req_old_q;

   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_address_q;
   assign MEM_WRITEDATA = mem_writedata_q;

   // Load data is the addressed word of a resident line, zero otherwise.
   always_comb begin
      CPU_READDATA = 32'd0;
      if (hit) begin
         CPU_READDATA = data_q[addr_idx][word_lsb +: 32];
      end
   end

   // Stall only on a miss in IDLE or on any access while a miss is in progress; never while reset is held.
   always_comb begin
      CPU_BUSYWAIT = 1'b0;
      if (RESET_N && access) begin
         CPU_BUSYWAIT = (state_q != S_IDLE) || !hit;
      end
   end

   // Next-state, memory request and array update logic.
   always_comb begin
      state_d         = state_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      buffer_d        = buffer_q;
      data_d          = data_q;
      tag_d           = tag_q;
      valid_d         = valid_q;
      dirty_d         = dirty_q;
      req_old_d       = (mem_read_q || mem_write_q) && !mem_done;

      case (state_q)
         S_IDLE: begin
            if (access && !hit) begin
               if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                  state_d         = S_WRITEBACK;
                  mem_write_d     = 1'b1;
                  mem_address_d   = {tag_q[addr_idx], addr_idx};
                  mem_writedata_d = data_q[addr_idx];
               end else begin
                  state_d       = S_FETCH;
                  mem_read_d    = 1'b1;
                  mem_address_d = CPU_ADDRESS[31:4];
               end
            end else if (access && CPU_WRITE) begin
               data_d[addr_idx][word_lsb +: 32] = CPU_WRITEDATA;
               dirty_d[addr_idx]                = 1'b1;
            end
         end
         S_WRITEBACK: begin
            if (mem_done) begin
               state_d       = S_FETCH;
               mem_write_d   = 1'b0;
               mem_read_d    = 1'b1;
               mem_address_d = CPU_ADDRESS[31:4];
            end
         end
         S_FETCH: begin
            if (mem_done) begin
               state_d    = S_UPDATE;
               mem_read_d = 1'b0;
               buffer_d   = MEM_READDATA;
            end
         end
         S_UPDATE: begin
            data_d[addr_idx]  = buffer_q;
            tag_d[addr_idx]   = addr_tag;
            valid_d[addr_idx] = 1'b1;
            dirty_d[addr_idx] = 1'b0;
            state_d           = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and array registers; reset drops any in-flight request and invalidates every line.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q         <= S_IDLE;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= 28'd0;
         mem_writedata_q <= 128'd0;
         buffer_q        <= 128'd0;
         req_old_q       <= 1'b0;
         valid_q         <= 8'd0;
         dirty_q         <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            data_q[i] <= 128'd0;
            tag_q[i]  <= 25'd0;
         end
      end else begin
         state_q         <= state_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         buffer_q        <= buffer_d;
         req_old_q       <= req_old_d;
         valid_q         <= valid_d;
         dirty_q         <= dirty_d;
         for (int i = 0; i < 8; i++) begin
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, multi-cycle corner sequences, then random accesses.
// Each access is timed in stall edges and checked against a line-level cache model and a block memory model.
// The memory model raises MEM_BUSYWAIT with each new request and holds it for 1 + extra_wait edges.
module tb_dcache_controller;

   logic         CLK = 1'b0;
   logic         RESET_N;
   logic         CPU_READ, CPU_WRITE;
   logic [31:0]  CPU_ADDRESS, CPU_WRITEDATA, CPU_READDATA;
   logic         CPU_BUSYWAIT;
   logic         MEM_READ, MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA, MEM_READDATA;
   logic         MEM_BUSYWAIT;

   int checks = 0;
   int errors = 0;

   dcache_controller dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE),
      .CPU_ADDRESS(CPU_ADDRESS), .CPU_WRITEDATA(CPU_WRITEDATA),
      .CPU_READDATA(CPU_READDATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
      .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'd0, a[15:2], 2'b00};
   endfunction

   // ---------------- block memory model ----------------
   logic [127:0] pmem [64];
   int           extra_wait = 0;
   int           mcnt = 0;
   logic         prev_rd = 1'b0, prev_wr = 1'b0;
   logic         new_req;
   int           n_fetch = 0, n_wb = 0, viol = 0;
   logic [27:0]  last_wb_addr = '0, snap_a = '0;
   logic [127:0] last_wb_data = '0, snap_d = '0;

   assign new_req      = (MEM_READ && !prev_rd) || (MEM_WRITE && !prev_wr);
   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (new_req || (mcnt < 1 + extra_wait));
   assign MEM_READDATA = pmem[MEM_ADDRESS[5:0]];

   always @(posedge CLK) begin
      if (MEM_READ || MEM_WRITE) mcnt <= new_req ? 1 : mcnt + 1;
      else                       mcnt <= 0;
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
         pmem[MEM_ADDRESS[5:0]] <= MEM_WRITEDATA;
         last_wb_addr <= MEM_ADDRESS;
         last_wb_data <= MEM_WRITEDATA;
         n_wb <= n_wb + 1;
      end
      if (MEM_READ && !MEM_BUSYWAIT) n_fetch <= n_fetch + 1;
      if (RESET_N) begin
         if (MEM_READ && MEM_WRITE) viol <= viol + 1;
         if (((MEM_READ && prev_rd) || (MEM_WRITE && prev_wr)) &&
             (MEM_ADDRESS != snap_a || (MEM_WRITE && MEM_WRITEDATA != snap_d)))
            viol <= viol + 1;
      end
      snap_a  <= MEM_ADDRESS;
      snap_d  <= MEM_WRITEDATA;
      prev_rd <= MEM_READ;
      prev_wr <= MEM_WRITE;
   end

   // ---------------- cache reference model ----------------
   logic [127:0] m_mem [64];
   logic [127:0] m_line [8];
   logic [24:0]  m_tag [8];
   logic [7:0]   m_v = '0, m_d = '0;

   task automatic model_reset();
      m_v = '0;
      m_d = '0;
   endtask

   task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input int ex,
                               output int stall, output logic [31:0] rdata,
                               output int wb, output logic [27:0] wb_a, output logic [127:0] wb_d);
      int idx, w;
      logic [24:0] tg;
      idx = int'(a[6:4]); w = int'(a[3:2]); tg = a[31:7];
      stall = 0; wb = 0; wb_a = '0; wb_d = '0; rdata = '0;
      if (rd == wr) return;
      if (!(m_v[idx] && m_tag[idx] == tg)) begin
         stall = 4 + ex;
         if (m_v[idx] && m_d[idx]) begin
            wb = 1; stall += 2 + ex;
            wb_a = {m_tag[idx], a[6:4]};
            wb_d = m_line[idx];
            m_mem[wb_a[5:0]] = m_line[idx];
         end
         m_line[idx] = m_mem[a[9:4]];
         m_tag[idx] = tg; m_v[idx] = 1'b1; m_d[idx] = 1'b0;
      end
      rdata = m_line[idx][w*32 +: 32];
      if (wr) begin
         m_line[idx][w*32 +: 32] = wd;
         m_d[idx] = 1'b1;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Presents one access, counts edges with CPU_BUSYWAIT high, samples load data once released.
   task automatic do_acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output int stall, output logic [31:0] rdata);
      @(negedge CLK);
      CPU_READ = rd; CPU_WRITE = wr; CPU_ADDRESS = a; CPU_WRITEDATA = wd;
      #1;
      stall = 0;
      while (CPU_BUSYWAIT && stall < 200) begin
         @(posedge CLK); stall++;
         @(negedge CLK); #1;
      end
      rdata = CPU_READDATA;
      @(posedge CLK); #1;
      CPU_READ = 1'b0; CPU_WRITE = 1'b0;
   endtask

   typedef struct {
      logic        rd, wr;
      logic [31:0] addr, wd;
      int          stall;
      logic        chk_rd;
      logic [31:0] rdata;
      int          nf, nw;
      logic [27:0] wb_addr;
      logic [31:0] wb_w1;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int st, ms, mwb, f0, w0;
      logic [31:0] rdat, mrd;
      logic [27:0] mwa;
      logic [127:0] mwd;
      string nm;

      for (int b = 0; b < 64; b++)
         for (int w = 0; w < 4; w++) begin
            pmem[b][w*32 +: 32]  = pat({22'd0, b[5:0], w[1:0], 2'b00});
            m_mem[b][w*32 +: 32] = pat({22'd0, b[5:0], w[1:0], 2'b00});
         end

      //            rd    wr    addr          wdata         stall chk   rdata              nf nw wb_addr  wb_w1
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        4,    1'b1, pat(32'h40),       1, 0, 28'h0,  32'h0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF, 0,    1'b0, 32'h0,             0, 0, 28'h0,  32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0,    1'b1, 32'hDEADBEEF,      0, 0, 28'h0,  32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_00C4, 32'h0,        6,    1'b1, pat(32'hC4),       1, 1, 28'h4,  32'hDEADBEEF};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        4,    1'b1, 32'hDEADBEEF,      1, 0, 28'h0,  32'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000_0044, 32'h12345678, 0,    1'b0, 32'h0,             0, 0, 28'h0,  32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0,    1'b1, 32'hDEADBEEF,      0, 0, 28'h0,  32'h0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        4,    1'b1, pat(32'h80),       1, 0, 28'h0,  32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        4,    1'b1, pat(32'h00),       1, 0, 28'h0,  32'h0};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h0BADF00D, 0,    1'b0, 32'h0,             0, 0, 28'h0,  32'h0};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_004B, 32'h0,        0,    1'b1, 32'h0BADF00D,      0, 0, 28'h0,  32'h0};

      // Reset with an access already presented.
      RESET_N = 1'b0; CPU_READ = 1'b1; CPU_WRITE = 1'b0;
      CPU_ADDRESS = 32'h40; CPU_WRITEDATA = '0;
      #3;
      chk("rst_busywait", CPU_BUSYWAIT, 0);
      chk("rst_mem_read", MEM_READ, 0);
      chk("rst_mem_write", MEM_WRITE, 0);
      chk("rst_mem_addr", MEM_ADDRESS, 0);
      chk("rst_mem_wdata", MEM_WRITEDATA, 0);
      chk("rst_readdata", CPU_READDATA, 0);
      CPU_READ = 1'b0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         f0 = n_fetch; w0 = n_wb;
         model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, 0, ms, mrd, mwb, mwa, mwd);
         do_acc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, st, rdat);
         nm = $sformatf("vec%0d", i);
         chk({nm, "_stall"}, st, vecs[i].stall);
         if (vecs[i].chk_rd) chk({nm, "_rdata"}, rdat, vecs[i].rdata);
         chk({nm, "_fetches"}, n_fetch - f0, vecs[i].nf);
         chk({nm, "_writebacks"}, n_wb - w0, vecs[i].nw);
         if (vecs[i].nw != 0) begin
            chk({nm, "_wb_addr"}, last_wb_addr, vecs[i].wb_addr);
            chk({nm, "_wb_word1"}, last_wb_data[63:32], vecs[i].wb_w1);
         end
      end

      // Slow memory: fetch held busy for 5 extra edges.
      extra_wait = 5;
      f0 = n_fetch;
      model_access(1'b1, 1'b0, 32'h100, 32'h0, 5, ms, mrd, mwb, mwa, mwd);
      do_acc(1'b1, 1'b0, 32'h100, 32'h0, st, rdat);
      chk("slow_stall", st, 9);
      chk("slow_rdata", rdat, pat(32'h100));
      chk("slow_fetches", n_fetch - f0, 1);

      // Reset pulsed in the middle of a fetch.
      @(negedge CLK);
      CPU_READ = 1'b1; CPU_ADDRESS = 32'h200;
      repeat (3) @(posedge CLK);
      #2;
      chk("midfetch_mem_read_before", MEM_READ, 1);
      RESET_N = 1'b0;
      #1;
      chk("midfetch_mem_read_drop", MEM_READ, 0);
      chk("midfetch_busywait", CPU_BUSYWAIT, 0);
      chk("midfetch_mem_addr", MEM_ADDRESS, 0);
      CPU_ADDRESS = 32'h44;
      #1;
      chk("midfetch_readdata_invalid", CPU_READDATA, 0);
      CPU_READ = 1'b0;
      model_reset();
      extra_wait = 0;
      @(negedge CLK);
      RESET_N = 1'b1;
      f0 = n_fetch; w0 = n_wb;
      model_access(1'b1, 1'b0, 32'h44, 32'h0, 0, ms, mrd, mwb, mwa, mwd);
      do_acc(1'b1, 1'b0, 32'h44, 32'h0, st, rdat);
      chk("post_reset_stall", st, 4);
      chk("post_reset_rdata", rdat, 32'hDEADBEEF);
      chk("post_reset_fetches", n_fetch - f0, 1);
      chk("post_reset_writebacks", n_wb - w0, 0);

      // Random accesses against the model.
      for (int i = 0; i < 300; i++) begin
         int k;
         logic rd, wr;
         logic [31:0] a, wd;
         k = $urandom_range(0, 9);
         rd = (k == 0) || (k >= 2 && k <= 5);
         wr = (k == 0) || (k >= 6);
         a  = $urandom_range(0, 1023);
         wd = $urandom;
         extra_wait = $urandom_range(0, 3);
         f0 = n_fetch; w0 = n_wb;
         model_access(rd, wr, a, wd, extra_wait, ms, mrd, mwb, mwa, mwd);
         do_acc(rd, wr, a, wd, st, rdat);
         nm = $sformatf("rnd%0d", i);
         chk({nm, "_stall"}, st, ms);
         if (rd && !wr) chk({nm, "_rdata"}, rdat, mrd);
         chk({nm, "_fetches"}, n_fetch - f0, (ms != 0) ? 1 : 0);
         chk({nm, "_writebacks"}, n_wb - w0, mwb);
         if (mwb != 0) begin
            chk({nm, "_wb_addr"}, last_wb_addr, mwa);
            chk({nm, "_wb_data"}, last_wb_data, mwd);
         end
      end

      chk("mem_request_stable_exclusive", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
